// File: rtl/fx3_transfer_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fx3_transfer_controller_if
// Description : Handshake/datapath bundle between the FX3 state machine, the
//               ADC capture FIFO and fx3_transfer_controller.
//               slave  modport : the transfer controller
//               master modport : the FX3 / FIFO side driving it
//   collectData    FX3 request: 1 = collect samples
//   testMode       FX3 test-mode request
//   readData       registered FX3-is-reading strobe
//   fifoUsedWords  FIFO fill level (FIFO_AW bits)
//   fifoFull       FIFO full flag
//   captureEnable  permits ADC-side FIFO writes
//   fifoFlush      synchronous FIFO clear
//   fifoReadEnable FIFO read strobe, one word per cycle
//   dataAvailable  burst ready (FX3 CTL_00)
//   overflow       sticky FIFO overflow flag
//   burstCount     completed bursts since last flush
//   testData       test-pattern word
// Revision    : 1.0 - initial release
// ============================================================================
interface fx3_transfer_controller_if #(
  parameter int FIFO_AW = 14
);
  logic               collectData;
  logic               testMode;
  logic               readData;
  logic [FIFO_AW-1:0] fifoUsedWords;
  logic               fifoFull;
  logic               captureEnable;
  logic               fifoFlush;
  logic               fifoReadEnable;
  logic               dataAvailable;
  logic               overflow;
  logic [15:0]        burstCount;
  logic [9:0]         testData;

  modport slave (
    input  collectData, testMode, readData, fifoUsedWords, fifoFull,
    output captureEnable, fifoFlush, fifoReadEnable, dataAvailable,
           overflow, burstCount, testData
  );

  modport master (
    output collectData, testMode, readData, fifoUsedWords, fifoFull,
    input  captureEnable, fifoFlush, fifoReadEnable, dataAvailable,
           overflow, burstCount, testData
  );
endinterface
`default_nettype wire

// File: rtl/fx3_transfer_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fx3_transfer_controller
// Description : Sequences sample transfer between the ADC capture FIFO and
//               the FX3 GPIF interface (fx3Clk domain). Gates ADC capture,
//               flushes the FIFO at collection start, raises dataAvailable
//               when a full burst is buffered, meters FIFO reads during FX3
//               bursts and traps FIFO overflow.
// Ports       : inclk   - fx3Clk (64 MHz)
//               nReset  - asynchronous active-low reset
//               bus     - fx3_transfer_controller_if.slave (see interface)
// Parameters  : FIFO_AW      - FIFO used-word count width
//               BURST_LEN    - words per burst / dataAvailable threshold
//               FLUSH_CYCLES - cycles fifoFlush is held at collection start
// Options     : TEST_COUNTER_EN - when defined, testMode=1 replaces the FIFO
//               path with a 10-bit counter on testData (ready immediately,
//               capture and overflow detection disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module fx3_transfer_controller #(
  parameter int FIFO_AW      = 14,
  parameter int BURST_LEN    = 8192,
  parameter int FLUSH_CYCLES = 4
) (
  input wire                        inclk,
  input wire                        nReset,
  fx3_transfer_controller_if.slave  bus
);

  localparam int                 FLUSH_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST   = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [FIFO_AW-1:0] WORD_LAST    = FIFO_AW'(BURST_LEN - 1);
  // One extra bit so a threshold equal to the FIFO depth is representable.
  localparam logic [FIFO_AW:0]   BURST_THRESH = (FIFO_AW+1)'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_ARMED     = 3'd2,
    S_AVAILABLE = 3'd3,
    S_BURST     = 3'd4,
    S_GAP       = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [FLUSH_W-1:0]   flushCnt_q, flushCnt_d;
  logic                 flushAbort_q, flushAbort_d;
  logic [FIFO_AW-1:0]   wordCnt_q, wordCnt_d;
  logic [15:0]          burstCount_q, burstCount_d;
  logic                 captureEnable_q, captureEnable_d;
  logic                 fifoFlush_q, fifoFlush_d;
  logic                 dataAvailable_q, dataAvailable_d;
  logic                 overflow_q, overflow_d;

  logic                 testActive;
  logic                 burstReady;
  logic                 overflowHit;
  logic                 readEnable;

  // --------------------------------------------------------------------------
  // Test-mode qualifier
  // --------------------------------------------------------------------------
`ifdef TEST_COUNTER_EN
  assign testActive = bus.testMode;
`else
  logic unused_testMode;
  assign testActive      = 1'b0;
  assign unused_testMode = bus.testMode;
`endif

  // The read strobe is already registered upstream, so the read enable is a
  // pure combinational qualification to avoid adding a cycle of latency.
  assign readEnable = (state_q == S_BURST) & bus.readData;

  assign burstReady = testActive | ({1'b0, bus.fifoUsedWords} >= BURST_THRESH);

  // captureEnable_q is only ever high in ARMED/AVAILABLE/BURST/GAP, so it
  // doubles as the "FIFO is being written" qualifier for overflow trapping.
  assign overflowHit = ~testActive & bus.fifoFull & captureEnable_q;

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    flushAbort_d = flushAbort_q;
    wordCnt_d    = wordCnt_q;
    burstCount_d = burstCount_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.collectData) begin
          state_d      = S_FLUSH;
          flushCnt_d   = '0;
          flushAbort_d = 1'b0;
          wordCnt_d    = '0;
          burstCount_d = '0;
          overflow_d   = 1'b0;
        end
      end

      S_FLUSH: begin
        // A stop request during the flush is remembered so the flush always
        // runs its full length before returning to IDLE.
        if (!bus.collectData) begin
          flushAbort_d = 1'b1;
        end
        if (flushCnt_q == FLUSH_LAST) begin
          flushCnt_d = '0;
          state_d    = (flushAbort_q || !bus.collectData) ? S_IDLE : S_ARMED;
        end else begin
          flushCnt_d = flushCnt_q + 1'b1;
        end
      end

      S_ARMED: begin
        if (!bus.collectData) begin
          state_d = S_IDLE;
        end else if (burstReady) begin
          state_d = S_AVAILABLE;
        end
      end

      S_AVAILABLE: begin
        // The strobe that moves us into BURST is not a read; reading starts
        // in the first BURST cycle.
        if (!bus.collectData) begin
          state_d = S_IDLE;
        end else if (bus.readData) begin
          state_d = S_BURST;
        end
      end

      S_BURST: begin
        // A stop request never truncates a burst; GAP decides where to go.
        if (bus.readData) begin
          if (wordCnt_q == WORD_LAST) begin
            wordCnt_d    = '0;
            burstCount_d = burstCount_q + 16'd1;
            state_d      = S_GAP;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
      end

      S_GAP: begin
        // Always passes through ARMED so dataAvailable is low at least one
        // cycle between bursts, even when the next burst is already buffered.
        if (!bus.readData) begin
          state_d = bus.collectData ? S_ARMED : S_IDLE;
        end
      end

      S_ERROR: begin
        if (!bus.collectData) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Overflow wins over every other transition.
    if (overflowHit) begin
      state_d    = S_ERROR;
      overflow_d = 1'b1;
    end
  end

  // Registered outputs are derived from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    captureEnable_d = 1'b0;
    fifoFlush_d     = 1'b0;
    dataAvailable_d = 1'b0;
    case (state_d)
      S_FLUSH: begin
        fifoFlush_d = 1'b1;
      end
      S_ARMED, S_GAP: begin
        captureEnable_d = ~testActive;
      end
      S_AVAILABLE, S_BURST: begin
        captureEnable_d = ~testActive;
        dataAvailable_d = 1'b1;
      end
      default: begin
        captureEnable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state_q         <= S_IDLE;
      flushCnt_q      <= '0;
      flushAbort_q    <= 1'b0;
      wordCnt_q       <= '0;
      burstCount_q    <= '0;
      captureEnable_q <= 1'b0;
      fifoFlush_q     <= 1'b0;
      dataAvailable_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      flushCnt_q      <= flushCnt_d;
      flushAbort_q    <= flushAbort_d;
      wordCnt_q       <= wordCnt_d;
      burstCount_q    <= burstCount_d;
      captureEnable_q <= captureEnable_d;
      fifoFlush_q     <= fifoFlush_d;
      dataAvailable_q <= dataAvailable_d;
      overflow_q      <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Test-pattern counter
  // --------------------------------------------------------------------------
`ifdef TEST_COUNTER_EN
  logic [9:0] testCnt_q, testCnt_d;

  always_comb begin
    testCnt_d = testCnt_q;
    if (state_q == S_FLUSH) begin
      testCnt_d = '0;
    end else if ((state_q != S_IDLE) && bus.testMode && readEnable) begin
      testCnt_d = testCnt_q + 10'd1;  // natural wrap 0x3FF -> 0x000
    end
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      testCnt_q <= '0;
    end else begin
      testCnt_q <= testCnt_d;
    end
  end

  assign bus.testData = testCnt_q;
`else
  assign bus.testData = '0;
`endif

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.captureEnable  = captureEnable_q;
  assign bus.fifoFlush      = fifoFlush_q;
  assign bus.fifoReadEnable = readEnable;
  assign bus.dataAvailable  = dataAvailable_q;
  assign bus.overflow       = overflow_q;
  assign bus.burstCount     = burstCount_q;

endmodule
`default_nettype wire

// File: doc/fx3_transfer_controller.md
Name: fx3_transfer_controller

Overview:
Sequences sample transfer between the ADC capture FIFO and the FX3 GPIF interface in the fx3Clk (64 MHz) domain.
- Gates ADC capture into the FIFO.
- Flushes the FIFO at the start of each collection.
- Raises dataAvailable when a full burst is buffered, and meters FIFO reads during FX3 bursts.
- Traps FIFO overflow.
- Sits between fx3StateMachine (registered read strobe) and the FIFO/dataGenerator datapath.

Parameters:
FIFO_AW, 14, FIFO used-word count width (16384-word FIFO)
BURST_LEN, 8192, words per FX3 burst; also the dataAvailable threshold; must be ≤ 2^FIFO_AW
FLUSH_CYCLES, 4, cycles fifoFlush is held at collection start

Ports:
inclk  in  1  system clock (fx3Clk, 64 MHz)
nReset  in  1  asynchronous active-low reset
collectData  in  1  FX3 request: 1 = collect samples
testMode  in  1  FX3 test-mode request
readData  in  1  registered FX3-is-reading strobe (from fx3StateMachine)
fifoUsedWords  in  FIFO_AW  FIFO fill level, inclk domain
fifoFull  in  1  FIFO full flag, inclk domain
captureEnable  out  1  permits ADC-side FIFO writes
fifoFlush  out  1  synchronous FIFO clear
fifoReadEnable  out  1  FIFO read strobe, one word per cycle
dataAvailable  out  1  to FX3 CTL_00: a burst is ready
overflow  out  1  sticky FIFO overflow flag
burstCount  out  16  completed bursts since last flush, wraps 0xFFFF→0
testData  out  10  test-pattern word (see Optional Feature)

Behaviour:
- Reset (async, nReset=0): state IDLE. All outputs 0. Flush and word counters 0. Release is synchronous to inclk.
- Outputs are registered, except fifoReadEnable = (state==BURST) & readData, which is combinational. This gives zero added latency on the already-registered strobe.
- IDLE:
  - captureEnable=0, dataAvailable=0.
  - collectData=1 → FLUSH.
- FLUSH:
  - fifoFlush=1 for exactly FLUSH_CYCLES cycles.
  - On entry, clears overflow, burstCount and the word counter.
  - Then → ARMED, with captureEnable=1 from the first ARMED cycle.
  - collectData=0 during FLUSH → finish the flush, then IDLE.
- ARMED:
  - fifoUsedWords ≥ BURST_LEN → AVAILABLE; dataAvailable=1 the next cycle.
  - collectData=0 → IDLE.
- AVAILABLE:
  - dataAvailable=1.
  - readData=1 → BURST. The read in that same cycle is not counted; fifoReadEnable starts in the BURST cycle.
  - collectData=0 → IDLE (dataAvailable drops).
- BURST:
  - Each cycle with readData=1 reads one word and increments the word counter.
  - readData=0 mid-burst pauses the burst; the count is held and no reads occur.
  - On the read that makes count = BURST_LEN: word counter → 0, burstCount+1, dataAvailable=0 on the same edge, → GAP.
  - collectData=0 does not abort a burst.
- GAP:
  - Wait for readData=0.
  - Then → ARMED if collectData=1, else IDLE.
  - Even if ≥BURST_LEN words remain, ARMED is visited for 1 cycle, giving a minimum 1-cycle dataAvailable low gap.
- ERROR:
  - Entered from ARMED, AVAILABLE, BURST or GAP when fifoFull=1 and captureEnable=1.
  - Sets overflow=1 and clears captureEnable and dataAvailable the next cycle; fifoReadEnable is forced 0.
  - Stays until collectData=0 → IDLE.
  - overflow stays 1 until the next FLUSH.
- Simultaneous events:
  - fifoFull has priority over every other transition.
  - Burst completion and collectData=0 in the same cycle → GAP, then IDLE.
- Reset mid-burst: immediate abort; all outputs 0. The FIFO is not flushed until the next collection start.

Optional Feature:
Macro TEST_COUNTER_EN.
- Defined:
  - In any non-IDLE state with testMode=1, a 10-bit counter increments on each fifoReadEnable cycle and drives testData; it wraps 0x3FF→0x000.
  - The ARMED→AVAILABLE condition ignores fifoUsedWords (always ready).
  - fifoFull/overflow detection is suppressed and captureEnable is held 0.
  - Counter resets to 0 in FLUSH.
- Not defined: testMode is ignored and testData is tied to 0.

Test Plan:
1. Reset and start: collectData=1 → fifoFlush high exactly 4 cycles, then captureEnable=1; all outputs 0 before that.
2. Burst: fifoUsedWords=8191 → dataAvailable stays 0; set 8192 → dataAvailable=1 next cycle. Hold readData=1 → exactly 8192 fifoReadEnable cycles, dataAvailable=0 on the last read edge, burstCount=1.
3. Paused burst: drop readData for 5 cycles after read 100 → total reads still exactly 8192, no read in the paused cycles.
4. Overflow: pulse fifoFull=1 in ARMED → overflow=1, captureEnable=0 next cycle, state held; collectData=0 then 1 → overflow cleared in FLUSH.
5. Stop mid-burst: collectData=0 after read 4000 → reads continue to 8192, then IDLE with captureEnable=0, no further dataAvailable.
6. TEST_COUNTER_EN, testMode=1: 1030 reads → testData sequence 0..1023, 0..5; fifoFull ignored.
